display_scanner: RTL and testbench

- Downstream consumer of the stopwatch's 16-bit BCD time word Q[16:1]: {min tens, min ones, sec tens, sec ones}, nibbles Q[16:13], Q[12:9], Q[8:5], Q[4:1].
- Drives a 4-digit multiplexed common-anode seven-segment display with:
  - frame-coherent snapshots of the time word;
  - a one-cycle anti-ghost gap between digits;
  - optional leading-zero blanking;
  - a colon (decimal point) that blinks while the stopwatch runs.

---
 rtl/display_pkg.sv | 28 ++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/display_scanner.sv | 118 +++++++++++
 tb/tb_display_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment scanner:
// active-high segment patterns, scan FSM states and digit positions.
package display_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [1:0] IDX_SEC_ONES = 2'd0;
    localparam logic [1:0] IDX_SEC_TENS = 2'd1;
    localparam logic [1:0] IDX_MIN_ONES = 2'd2;
    localparam logic [1:0] IDX_MIN_TENS = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// Nibble to active-high {g..a} segment pattern.
// Non-BCD codes show a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with frame snapshots,
// anti-ghost gap, leading-zero blanking and a blinking colon.
module display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic [15:0] BCD,
    input  logic        RUNNING,
    input  logic        BLANK_LZ,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam bit INV = (ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_IDLE = INV ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_IDLE  = INV ? 4'hF : 4'h0;
    localparam logic       DP_IDLE  = INV;

    state_t          state, state_n;
    logic [PW-1:0]   prescaler, pre_n;
    logic [1:0]      idx, idx_n;
    logic [15:0]     snapshot, snap_n;
    logic [FW-1:0]   frame_cnt, fcnt_n;
    logic            colon_phase, phase_n;
    logic            tick, wrap, blank, lit;
    logic [3:0]      nibble, an_n;
    logic [6:0]      pattern, seg_n;
    logic            dp_n;

    bcd_to_7seg u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // Outputs are decoded from next-state values so the pins line up
    // with the FSM state register rather than lagging it by a cycle.
    always_comb begin
        tick    = (prescaler == PW'(SCAN_DIV - 1));
        pre_n   = tick ? '0 : prescaler + PW'(1);
        state_n = state;
        idx_n   = idx;
        wrap    = 1'b0;
        unique case (state)
            GAP:  state_n = SHOW;
            SHOW: begin
                if (tick) begin
                    state_n = GAP;
                    idx_n   = idx + 2'd1;
                    wrap    = (idx == IDX_MIN_TENS);
                end
            end
        endcase

        snap_n = wrap ? BCD : snapshot;

        fcnt_n  = frame_cnt;
        phase_n = colon_phase;
        if (!RUNNING) begin
            fcnt_n  = '0;
            phase_n = 1'b1;
        end else if (wrap) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt_n  = '0;
                phase_n = ~colon_phase;
            end else begin
                fcnt_n = frame_cnt + FW'(1);
            end
        end

        nibble = 4'h0;
        unique case (idx_n)
            IDX_SEC_ONES: nibble = snap_n[3:0];
            IDX_SEC_TENS: nibble = snap_n[7:4];
            IDX_MIN_ONES: nibble = snap_n[11:8];
            IDX_MIN_TENS: nibble = snap_n[15:12];
        endcase

        blank = BLANK_LZ && (idx_n == IDX_MIN_TENS) && (nibble == 4'h0);
        lit   = (state_n == SHOW) && !blank;
        an_n  = lit ? (4'b0001 << idx_n) : 4'b0000;
        seg_n = lit ? pattern : SEG_OFF;
        dp_n  = lit && (idx_n == IDX_MIN_ONES) && phase_n;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= GAP;
            prescaler   <= '0;
            idx         <= IDX_SEC_ONES;
            snapshot    <= 16'h0000;
            frame_cnt   <= '0;
            colon_phase <= 1'b1;
            SEG         <= SEG_IDLE;
            AN          <= AN_IDLE;
            DP          <= DP_IDLE;
        end else begin
            state       <= state_n;
            prescaler   <= pre_n;
            idx         <= idx_n;
            snapshot    <= snap_n;
            frame_cnt   <= fcnt_n;
            colon_phase <= phase_n;
            SEG         <= INV ? ~seg_n : seg_n;
            AN          <= INV ? ~an_n : an_n;
            DP          <= INV ? ~dp_n : dp_n;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: expected pin words per cycle
// are queued frame by frame and compared at each falling edge.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b1;
    logic [15:0] BCD = 16'h1234;
    logic        RUNNING = 1'b0;
    logic        BLANK_LZ = 1'b0;
    logic [6:0]  SEG;
    logic        DP;
    logic [3:0]  AN;

    int    total = 0;
    int    bad = 0;
    int    k = 0;
    string tag = "init";

    logic [11:0] sb[$];

    localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};

    display_scanner #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .BCD      (BCD),
        .RUNNING  (RUNNING),
        .BLANK_LZ (BLANK_LZ),
        .SEG      (SEG),
        .DP       (DP),
        .AN       (AN)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_hi(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [11:0] lit_word(input int d, input logic [3:0] n,
                                             input bit dp_on);
        logic [3:0] an;
        an = 4'b1111;
        an[d] = 1'b0;
        return {an, ~seg_hi(n), ~dp_on};
    endfunction

    // One frame as seen from its GAP cycle: per digit 1 off + 3 lit.
    task automatic push_frame(input logic [15:0] snap, input bit blank,
                              input bit colon);
        logic [3:0] nib;
        for (int d = 0; d < 4; d++) begin
            nib = snap[4*d +: 4];
            sb.push_back(OFF);
            for (int c = 0; c < 3; c++) begin
                if (blank && d == 3 && nib == 4'h0)
                    sb.push_back(OFF);
                else
                    sb.push_back(lit_word(d, nib, colon && d == 2));
            end
        end
    endtask

    task automatic check_now(input logic [11:0] exp);
        total++;
        assert ({AN, SEG, DP} === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got AN=%b SEG=%h DP=%b want AN=%b SEG=%h DP=%b",
                   tag, k, AN, SEG, DP, exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic run(input int n);
        logic [11:0] e;
        repeat (n) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s k=%0d scoreboard empty", tag, k);
            end else begin
                e = sb.pop_front();
                check_now(e);
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #3 RESET_N = 1'b0;
        #1 tag = "reset_async";
        check_now(OFF);
        @(negedge clk);
        tag = "reset_hold";
        check_now(OFF);
        @(negedge clk);
        check_now(OFF);

        RESET_N = 1'b1;
        k = 0;
        tag = "boot";
        push_frame(16'h0000, 1'b0, 1'b1);
        run(16);

        tag = "order";
        push_frame(16'h1234, 1'b0, 1'b1);
        run(16);

        tag = "tear";
        push_frame(16'h1234, 1'b0, 1'b1);
        run(6);
        BCD = 16'h4059;
        run(10);

        tag = "tear_next";
        BCD = 16'h0959;
        BLANK_LZ = 1'b1;
        push_frame(16'h4059, 1'b1, 1'b1);
        run(16);

        tag = "lz_blank";
        push_frame(16'h0959, 1'b1, 1'b1);
        run(16);

        tag = "lz_show";
        BLANK_LZ = 1'b0;
        BCD = 16'h00A0;
        push_frame(16'h0959, 1'b0, 1'b1);
        run(16);

        tag = "dash";
        RUNNING = 1'b1;
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);

        tag = "blink";
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);
        push_frame(16'h00A0, 1'b0, 1'b0);
        run(16);
        push_frame(16'h00A0, 1'b0, 1'b0);
        run(16);
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);

        tag = "blink_stop";
        push_frame(16'h00A0, 1'b0, 1'b0);
        run(13);
        RUNNING = 1'b0;
        run(3);

        tag = "steady";
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(16);

        tag = "mid_reset";
        BCD = 16'h0742;
        push_frame(16'h00A0, 1'b0, 1'b1);
        run(6);
        #2 RESET_N = 1'b0;
        #1 check_now(OFF);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check_now(OFF);
        end

        RESET_N = 1'b1;
        k = 0;
        tag = "restart";
        push_frame(16'h0000, 1'b0, 1'b1);
        run(16);
        tag = "resnap";
        push_frame(16'h0742, 1'b0, 1'b1);
        run(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
